// File: rtl/keypad_entry.sv
// Microwave keypad receive path: debounces a one-hot keypad, encodes the digit to BCD
// and shifts accepted digits into a 3-digit M:SS entry register.
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [9:0] keypad,
  input  logic       clearn,
  input  logic       load_en,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_mins,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic       entry_nonzero
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       pattern;

  logic       is_onehot;
  logic [3:0] enc;
  logic       accept;
  logic [3:0] nxt_mins, nxt_tens, nxt_ones;

  always_comb begin
    is_onehot = (keypad != '0) && ((keypad & (keypad - 10'd1)) == '0);
    enc = '0;
    for (int i = 0; i < 10; i++)
      if (keypad[i]) enc = 4'(i);
  end

  assign accept = (state == DEBOUNCE) && (keypad == pattern) && (cnt == CNT_LAST);

  // Clear overrides a same-edge shift; the key is still reported as accepted.
  always_comb begin
    nxt_mins = digit_mins;
    nxt_tens = digit_tens;
    nxt_ones = digit_ones;
    if (accept && load_en) begin
      nxt_mins = digit_tens;
      nxt_tens = digit_ones;
      nxt_ones = enc;
    end
    if (!clearn) begin
      nxt_mins = '0;
      nxt_tens = '0;
      nxt_ones = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cnt           <= '0;
      pattern       <= '0;
      key_valid     <= 1'b0;
      key_code      <= '0;
      digit_mins    <= '0;
      digit_tens    <= '0;
      digit_ones    <= '0;
      entry_nonzero <= 1'b0;
    end else begin
      key_valid     <= accept && load_en;
      if (accept) key_code <= enc;
      digit_mins    <= nxt_mins;
      digit_tens    <= nxt_tens;
      digit_ones    <= nxt_ones;
      entry_nonzero <= |{nxt_mins, nxt_tens, nxt_ones};
      case (state)
        IDLE:
          if (is_onehot) begin
            pattern <= keypad;
            cnt     <= CNT_W'(1);
            state   <= DEBOUNCE;
          end
        DEBOUNCE:
          if (keypad != pattern) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= HELD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        HELD:
          // Extra or changed keys are ignored until the pad is fully released.
          if (keypad == '0) begin
            cnt   <= CNT_W'(1);
            state <= RELEASE;
          end
        RELEASE:
          if (keypad != '0) begin
            cnt   <= '0;
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
